// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encoding and a conditional two's-complement helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [31:0] negate_if(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring shift-subtract divider on operand magnitudes, one quotient bit per
// step; signs of quotient and remainder are applied on the outputs.
module muldiv_divider
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        step,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic        q_neg;
  logic        r_neg;
  logic [32:0] shifted;

  // quo doubles as the dividend shift register; quotient bits enter at the bottom.
  assign shifted = {rem, quo[31]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo   <= '0;
      dvs   <= '0;
      rem   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (load) begin
      quo   <= negate_if(dividend, is_signed && dividend[31]);
      dvs   <= negate_if(divisor, is_signed && divisor[31]);
      rem   <= '0;
      q_neg <= is_signed && (dividend[31] ^ divisor[31]);
      r_neg <= is_signed && dividend[31];
    end else if (step) begin
      if (shifted >= {1'b0, dvs}) begin
        rem <= shifted[31:0] - dvs;
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= shifted[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

  assign quotient  = negate_if(quo, q_neg);
  assign remainder = negate_if(rem, r_neg);

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit with a 32-iteration shift-add multiplier.
// Define MULDIV_DIV_EN to build the divider; without it divide ops return 0 and pulse illegal.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic [1:0]      state_dbg
);

  // Handshake: start is accepted only in IDLE or DONE; busy covers the whole
  // operation and drops in the single cycle that done is high with result valid.
  state_t      state;
  logic [5:0]  cnt;
  logic [2:0]  f3_q;
  logic        neg_q;
  logic        illegal_q;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] product;
  logic        a_neg;
  logic        b_neg;
  logic        accept;

  assign accept    = start && (state == ST_IDLE || state == ST_DONE);
  assign a_neg     = op_a[31] && (funct3 == F3_MULH || funct3 == F3_MULHSU);
  assign b_neg     = op_b[31] && (funct3 == F3_MULH);
  assign product   = neg_q ? (~acc + 64'd1) : acc;
  assign busy      = (state == ST_MUL) || (state == ST_DIV);
  assign done      = (state == ST_DONE);
  assign illegal   = done && illegal_q;
  assign state_dbg = state;

`ifdef MULDIV_DIV_EN
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [31:0] div_result;
  logic        div_zero;
  logic        div_ovf;
  logic        div_skip;
  logic        div_step;

  assign div_zero = (b_q == 32'd0);
  assign div_ovf  = !f3_q[0] && a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF;
  assign div_skip = div_zero || div_ovf;
  assign div_step = (state == ST_DIV) && (cnt != 6'd32) && !div_skip;

  muldiv_divider u_divider (
    .clk,
    .resetn,
    .load      (accept && funct3[2]),
    .step      (div_step),
    .is_signed (funct3 == F3_DIV || funct3 == F3_REM),
    .dividend  (op_a),
    .divisor   (op_b),
    .quotient,
    .remainder
  );

  always_comb begin
    div_result = '0;
    if (div_zero)     div_result = f3_q[1] ? a_q : 32'hFFFF_FFFF;
    else if (div_ovf) div_result = f3_q[1] ? 32'd0 : 32'h8000_0000;
    else              div_result = f3_q[1] ? remainder : quotient;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= op_a;
      b_q <= op_b;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      illegal_q <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      result    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          illegal_q <= 1'b0;
          if (start) begin
            f3_q   <= funct3;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {32'd0, negate_if(op_a, a_neg)};
            mplier <= negate_if(op_b, b_neg);
            neg_q  <= a_neg ^ b_neg;
            state  <= funct3[2] ? ST_DIV : ST_MUL;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          // 32 add/shift steps, then one cycle to apply the sign and pick the half.
          if (cnt == 6'd32) begin
            result <= (f3_q == F3_MUL) ? product[31:0] : product[63:32];
            state  <= ST_DONE;
          end else begin
            acc    <= acc + (mplier[0] ? mcand : 64'd0);
            mcand  <= {mcand[62:0], 1'b0};
            mplier <= {1'b0, mplier[31:1]};
            cnt    <= cnt + 6'd1;
          end
        end
        ST_DIV: begin
`ifdef MULDIV_DIV_EN
          if (div_skip || cnt == 6'd32) begin
            result <= div_result;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + 6'd1;
          end
`else
          result    <= '0;
          illegal_q <= 1'b1;
          state     <= ST_DONE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
